// File: rtl/router_out_arbiter_pkg.sv
// Purpose: shared constants, virtual-channel type and helpers for the
//          router output-port arbiter.
// Contents: PACKET_WIDTH, NUM_REQ, VC_BIT defaults, RR_PTR_W, vc_e, vc_of().
package router_out_arbiter_pkg;

   localparam int unsigned PACKET_WIDTH = 64;
   localparam int unsigned NUM_REQ      = 4;
   localparam int unsigned VC_BIT       = 63;
   localparam int unsigned RR_PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      VC_EVEN = 1'b0,
      VC_ODD  = 1'b1
   } vc_e;

   // Virtual channel carried by a packet.
   function automatic vc_e vc_of(input logic [PACKET_WIDTH-1:0] pkt);
      return vc_e'(pkt[VC_BIT]);
   endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Purpose: requester/link bundle of one router output port.
// Signals: polarity, gnt, out_so, out_do (arbiter -> world);
//          req, req_data, out_ro (world -> arbiter).
// Modports: master = arbiter side, slave = requesters/link side.
interface router_out_arbiter_if #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned PACKET_WIDTH = 64
);

   logic                            polarity;
   logic [NUM_REQ-1:0]              req;
   logic [NUM_REQ*PACKET_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]              gnt;
   logic                            out_so;
   logic                            out_ro;
   logic [PACKET_WIDTH-1:0]         out_do;

   modport master (
      output polarity, gnt, out_so, out_do,
      input  req, req_data, out_ro
   );

   modport slave (
      input  polarity, gnt, out_so, out_do,
      output req, req_data, out_ro
   );

endinterface

// File: rtl/router_out_arbiter_rr_arbiter.sv
// Purpose: combinational round-robin pick: first requester at or after
//          i_start, scanning upward with wrap.
// Ports: i_req (request vector), i_start (priority pointer),
//        o_gnt (one-hot), o_idx (winner index), o_valid (any winner).
module router_out_arbiter_rr_arbiter
   import router_out_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = router_out_arbiter_pkg::NUM_REQ,
   parameter int unsigned PTR_W   = router_out_arbiter_pkg::RR_PTR_W
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [PTR_W-1:0]   i_start,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [PTR_W-1:0]   o_idx,
   output logic               o_valid
);

   int w_best;
   int w_dist;

   // Winner is the requester with the smallest wrapped distance from i_start.
   always_comb begin
      w_best  = int'(NUM_REQ);
      w_dist  = 0;
      o_idx   = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_dist = (i + int'(NUM_REQ) - int'(i_start)) % int'(NUM_REQ);
         if (i_req[i] && (w_dist < w_best)) begin
            w_best = w_dist;
            o_idx  = PTR_W'(i);
         end
      end
      o_valid = (w_best < int'(NUM_REQ));
      o_gnt   = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         o_gnt[i] = o_valid && (o_idx == PTR_W'(i));
      end
   end

endmodule

// File: rtl/router_out_arbiter.sv
// Purpose: output-port controller. Alternates polarity every cycle; the VC
//          equal to polarity accepts one packet from the requesters, the
//          other VC drains its one-entry buffer onto the link.
// Ports: clk, reset (async, active-high), bus (router_out_arbiter_if.master):
//        polarity, gnt (same-cycle one-hot), out_so/out_ro/out_do link.
module router_out_arbiter
   import router_out_arbiter_pkg::*;
#(
   parameter int unsigned PACKET_WIDTH = router_out_arbiter_pkg::PACKET_WIDTH,
   parameter int unsigned NUM_REQ      = router_out_arbiter_pkg::NUM_REQ,
   parameter int unsigned VC_BIT       = router_out_arbiter_pkg::VC_BIT
) (
   input  logic                  clk,
   input  logic                  reset,
   router_out_arbiter_if.master  bus
);

   localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic                    r_pol;
   logic [1:0]              r_valid;
   logic [PACKET_WIDTH-1:0] r_buf [2];
   logic [PTR_W-1:0]        r_rr  [2];

   logic [NUM_REQ-1:0]      w_elig;
   logic [NUM_REQ-1:0]      w_gnt;
   logic [PTR_W-1:0]        w_idx;
   logic                    w_any;
   logic                    w_so;
   logic [PACKET_WIDTH-1:0] w_win_data;

   // Requesters targeting the accepting VC, only while its buffer is free.
   always_comb begin
      w_elig = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         w_elig[i] = bus.req[i]
                   & (bus.req_data[i*int'(PACKET_WIDTH) + int'(VC_BIT)] == r_pol)
                   & ~r_valid[r_pol];
      end
   end

   router_out_arbiter_rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_rr (
      .i_req   (w_elig),
      .i_start (r_rr[r_pol]),
      .o_gnt   (w_gnt),
      .o_idx   (w_idx),
      .o_valid (w_any)
   );

   // Winner's packet.
   always_comb begin
      w_win_data = '0;
      for (int i = 0; i < int'(NUM_REQ); i++) begin
         if (w_gnt[i]) w_win_data = bus.req_data[i*int'(PACKET_WIDTH) +: PACKET_WIDTH];
      end
   end

   assign w_so         = r_valid[~r_pol] & bus.out_ro;
   assign bus.polarity = r_pol;
   assign bus.gnt      = reset ? '0 : w_gnt;
   assign bus.out_so   = w_so;
   assign bus.out_do   = w_so ? r_buf[~r_pol] : '0;

   // Accept into VC r_pol and drain VC ~r_pol; the two never touch the same entry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pol   <= 1'b0;
         r_valid <= 2'b00;
         for (int v = 0; v < 2; v++) begin
            r_buf[v] <= '0;
            r_rr[v]  <= '0;
         end
      end else begin
         r_pol <= ~r_pol;
         if (w_any) begin
            r_buf[r_pol]   <= w_win_data;
            r_valid[r_pol] <= 1'b1;
            r_rr[r_pol]    <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
         end
         if (w_so) r_valid[~r_pol] <= 1'b0;
      end
   end

endmodule
